// File: rtl/sr_latch_sched.sv
// Round-robin arbiter/sequencer sharing one SR latch among REQ_N requesters; drives non-overlapping s/r pulses.
// Define SR_CHECK_EN to compare latch_q/latch_qbar against the expected value after every pulse (sticky err).
module sr_latch_sched #(
    parameter int REQ_N     = 4,
    parameter int PULSE_CYC = 2,
    parameter int GAP_CYC   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [REQ_N-1:0]         req_valid,
    input  logic [REQ_N-1:0]         req_op,
    output logic [REQ_N-1:0]         req_ready,
    output logic                     latch_s,
    output logic                     latch_r,
    input  logic                     latch_q,
    input  logic                     latch_qbar,
    output logic                     exp_q,
    output logic [$clog2(REQ_N)-1:0] grant_id,
    output logic                     busy,
    output logic                     err
);

    localparam int ID_W    = $clog2(REQ_N);
    localparam int CNT_MAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    // state  | meaning
    // INIT   | clearing r-pulse after reset
    // IDLE   | arbitrating, ready may be asserted
    // PULSE  | s or r held high for the accepted command
    // GAP    | s=r=0 guard time before the next grant
    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_PULSE,
        ST_GAP
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [ID_W-1:0]   rr_ptr, rr_nxt;
    logic [ID_W-1:0]   gid_nxt;
    logic              cmd_op, op_nxt;
    logic              chk_pend, chk_nxt;
    logic              s_nxt, r_nxt, exp_nxt, busy_nxt, err_nxt;

    logic              win_found;
    logic [ID_W-1:0]   win_idx;
    logic              win_op;
    int                idx;

    // first valid requester at or after rr_ptr, wrapping
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int k = 0; k < REQ_N; k++) begin
            idx = (int'(rr_ptr) + k) % REQ_N;
            if (!win_found && req_valid[ID_W'(idx)]) begin
                win_found = 1'b1;
                win_idx   = ID_W'(idx);
            end
        end
    end

    assign win_op = req_op[win_idx];

    always_comb begin
        req_ready = '0;
        if (state == ST_IDLE && win_found) begin
            req_ready[win_idx] = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        s_nxt     = 1'b0;
        r_nxt     = 1'b0;
        exp_nxt   = exp_q;
        gid_nxt   = grant_id;
        rr_nxt    = rr_ptr;
        op_nxt    = cmd_op;
        chk_nxt   = 1'b0;
        case (state)
            ST_INIT: begin
                if (!latch_r) begin
                    r_nxt   = 1'b1;
                    cnt_nxt = PULSE_LD;
                end else if (cnt != '0) begin
                    r_nxt   = 1'b1;
                    cnt_nxt = cnt - 1'b1;
                end else begin
                    exp_nxt = 1'b0;
                    chk_nxt = 1'b1;
                    if (GAP_CYC > 0) begin
                        state_nxt = ST_GAP;
                        cnt_nxt   = GAP_LD;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_IDLE: begin
                if (win_found) begin
                    gid_nxt = win_idx;
                    rr_nxt  = ID_W'((int'(win_idx) + 1) % REQ_N);
                    // a command matching the stored value needs no pulse
                    if (win_op != exp_q) begin
                        state_nxt = ST_PULSE;
                        cnt_nxt   = PULSE_LD;
                        op_nxt    = win_op;
                        s_nxt     = win_op;
                        r_nxt     = ~win_op;
                    end
                end
            end
            ST_PULSE: begin
                if (cnt != '0) begin
                    s_nxt   = cmd_op;
                    r_nxt   = ~cmd_op;
                    cnt_nxt = cnt - 1'b1;
                end else begin
                    exp_nxt = cmd_op;
                    chk_nxt = 1'b1;
                    if (GAP_CYC > 0) begin
                        state_nxt = ST_GAP;
                        cnt_nxt   = GAP_LD;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - 1'b1;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_INIT;
            end
        endcase
        busy_nxt = (state_nxt != ST_IDLE);
    end

`ifdef SR_CHECK_EN
    assign err_nxt = err | (chk_pend & ((latch_q != exp_q) | (latch_qbar != ~exp_q)));
`else
    logic unused_fb;
    assign unused_fb = latch_q ^ latch_qbar;
    assign err_nxt   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_INIT;
            cnt      <= '0;
            latch_s  <= 1'b0;
            latch_r  <= 1'b0;
            exp_q    <= 1'b0;
            grant_id <= '0;
            rr_ptr   <= '0;
            cmd_op   <= 1'b0;
            chk_pend <= 1'b0;
            busy     <= 1'b1;
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            latch_s  <= s_nxt;
            latch_r  <= r_nxt;
            exp_q    <= exp_nxt;
            grant_id <= gid_nxt;
            rr_ptr   <= rr_nxt;
            cmd_op   <= op_nxt;
            chk_pend <= chk_nxt;
            busy     <= busy_nxt;
            err      <= err_nxt;
        end
    end

endmodule
